// File: rtl/ppu_reg_file.sv
// CPU-facing PPU register file ($2000-$2007): register decode, write toggle, VRAM address,
// PPUDATA read buffer, OAM port with DMA override, and NMI generation.
module ppu_reg_file #(
  parameter int                 VRAM_AW  = 14,
  parameter logic [VRAM_AW-1:0] PAL_BASE = 14'h3F00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs_n,
  input  logic [2:0]         reg_addr,
  input  logic               cpu_we,
  input  logic               cpu_re,
  input  logic [7:0]         cpu_wr_data,
  output logic [7:0]         cpu_rd_data,
  input  logic               vblank_set,
  input  logic               vblank_clr,
  input  logic               spr0_set,
  input  logic               ovf_set,
  output logic [7:0]         ctrl,
  output logic [7:0]         mask,
  output logic [7:0]         scroll_x,
  output logic [7:0]         scroll_y,
  output logic               nmi,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wr_data,
  output logic               vram_we,
  output logic               vram_re,
  input  logic [7:0]         vram_rd_data,
  input  logic [7:0]         pal_rd_data,
  input  logic               dma_active,
  input  logic [7:0]         dma_oam_addr,
  input  logic [7:0]         dma_data,
  input  logic               dma_we,
  output logic [7:0]         oam_addr,
  output logic [7:0]         oam_wr_data,
  output logic               oam_we,
  input  logic [7:0]         oam_rd_data,
  output logic [2:0]         dbg_state
);
  // Strobes are single-cycle pulses qualified by cs_n; a strobe is accepted when cs_n=0 and
  // cpu_we/cpu_re is high on a rising clk edge. There is no back-pressure.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OAM_WR = 3'd1,
    V_WR   = 3'd2,
    V_RQ   = 3'd3,
    V_CAP  = 3'd4
  } state_t;

  state_t             state_q;
  logic               oam_we_q, vram_we_q, vram_re_q;
  logic [7:0]         ctrl_q, ctrl_d, mask_q, mask_d;
  logic [7:0]         scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
  logic [7:0]         oam_addr_q, oam_addr_d, rd_buf_q, rd_buf_d;
  logic [7:0]         io_latch_q, io_latch_d, xfer_q, xfer_d;
  logic [5:0]         hi_q, hi_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d, vinc;
  logic               w_q, w_d;
  logic               vblank_q, vblank_d, spr0_q, spr0_d, ovf_q, ovf_d;
  logic               wr_acc, rd_acc, is_idle, status_rd;
  logic               start_oam_wr, start_v_wr, start_v_rd;

  assign wr_acc       = ~cs_n & cpu_we;
  assign rd_acc       = ~cs_n & cpu_re;
  assign is_idle      = (state_q == IDLE);
  assign status_rd    = rd_acc & (reg_addr == 3'd2);
  assign start_oam_wr = wr_acc & (reg_addr == 3'd4) & is_idle & ~dma_active;
  assign start_v_wr   = wr_acc & (reg_addr == 3'd7) & is_idle;
  assign start_v_rd   = rd_acc & (reg_addr == 3'd7) & is_idle;
  assign vinc         = ctrl_q[2] ? VRAM_AW'(32) : VRAM_AW'(1);

  always_comb begin
    ctrl_d      = ctrl_q;
    mask_d      = mask_q;
    scroll_x_d  = scroll_x_q;
    scroll_y_d  = scroll_y_q;
    oam_addr_d  = oam_addr_q;
    rd_buf_d    = rd_buf_q;
    io_latch_d  = io_latch_q;
    xfer_d      = xfer_q;
    hi_d        = hi_q;
    vram_addr_d = vram_addr_q;
    w_d         = w_q;
    if (wr_acc) begin
      io_latch_d = cpu_wr_data;
      case (reg_addr)
        3'd0: ctrl_d = cpu_wr_data;
        3'd1: mask_d = cpu_wr_data;
        3'd3: if (!dma_active) oam_addr_d = cpu_wr_data;
        3'd5: begin
          if (w_q) scroll_y_d = cpu_wr_data;
          else     scroll_x_d = cpu_wr_data;
          w_d = ~w_q;
        end
        3'd6: begin
          if (w_q) vram_addr_d = VRAM_AW'({hi_q, cpu_wr_data});
          else     hi_d = cpu_wr_data[5:0];
          w_d = ~w_q;
        end
        default: ;
      endcase
    end
    if (status_rd) w_d = 1'b0;
    if (start_oam_wr || start_v_wr) xfer_d = cpu_wr_data;
    // Post-access increments take precedence over a same-cycle $2003/$2006 write.
    case (state_q)
      OAM_WR:      oam_addr_d  = oam_addr_q + 8'd1;
      V_WR, V_RQ:  vram_addr_d = vram_addr_q + vinc;
      V_CAP:       rd_buf_d    = vram_rd_data;
      default: ;
    endcase
  end

  // A STATUS read racing vblank_set wins: the read sees 0 and the set is lost.
  always_comb begin
    vblank_d = vblank_q;
    if (vblank_clr)      vblank_d = 1'b0;
    else if (status_rd)  vblank_d = 1'b0;
    else if (vblank_set) vblank_d = 1'b1;
    spr0_d = vblank_clr ? 1'b0 : (spr0_set ? 1'b1 : spr0_q);
    ovf_d  = vblank_clr ? 1'b0 : (ovf_set  ? 1'b1 : ovf_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q      <= '0;
      mask_q      <= '0;
      scroll_x_q  <= '0;
      scroll_y_q  <= '0;
      oam_addr_q  <= '0;
      rd_buf_q    <= '0;
      io_latch_q  <= '0;
      xfer_q      <= '0;
      hi_q        <= '0;
      vram_addr_q <= '0;
      w_q         <= 1'b0;
      vblank_q    <= 1'b0;
      spr0_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      mask_q      <= mask_d;
      scroll_x_q  <= scroll_x_d;
      scroll_y_q  <= scroll_y_d;
      oam_addr_q  <= oam_addr_d;
      rd_buf_q    <= rd_buf_d;
      io_latch_q  <= io_latch_d;
      xfer_q      <= xfer_d;
      hi_q        <= hi_d;
      vram_addr_q <= vram_addr_d;
      w_q         <= w_d;
      vblank_q    <= vblank_d;
      spr0_q      <= spr0_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      oam_we_q  <= 1'b0;
      vram_we_q <= 1'b0;
      vram_re_q <= 1'b0;
    end else begin
      oam_we_q  <= 1'b0;
      vram_we_q <= 1'b0;
      vram_re_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_oam_wr) begin
            state_q  <= OAM_WR;
            oam_we_q <= 1'b1;
          end else if (start_v_wr) begin
            state_q   <= V_WR;
            vram_we_q <= 1'b1;
          end else if (start_v_rd) begin
            state_q   <= V_RQ;
            vram_re_q <= 1'b1;
          end
        end
        V_RQ:    state_q <= V_CAP;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (reg_addr)
      3'd2:    cpu_rd_data = {vblank_q & ~vblank_set, spr0_q, ovf_q, io_latch_q[4:0]};
      3'd4:    cpu_rd_data = oam_rd_data;
      3'd7:    cpu_rd_data = (vram_addr_q >= PAL_BASE) ? pal_rd_data : rd_buf_q;
      default: cpu_rd_data = io_latch_q;
    endcase
  end

  assign ctrl         = ctrl_q;
  assign mask         = mask_q;
  assign scroll_x     = scroll_x_q;
  assign scroll_y     = scroll_y_q;
  assign nmi          = ctrl_q[7] & vblank_q;
  assign vram_addr    = vram_addr_q;
  assign vram_wr_data = xfer_q;
  assign vram_we      = vram_we_q;
  assign vram_re      = vram_re_q;
  assign oam_addr     = dma_active ? dma_oam_addr : oam_addr_q;
  assign oam_wr_data  = dma_active ? dma_data     : xfer_q;
  assign oam_we       = dma_active ? dma_we       : oam_we_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_ppu_reg_file.sv
// Directed bench for ppu_reg_file: register write table, then hand sequences for VRAM,
// STATUS/NMI, OAM/DMA and reset corner cases, with VRAM and OAM write scoreboards.
module tb_ppu_reg_file;
  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n, cpu_we, cpu_re;
  logic [2:0]  reg_addr;
  logic [7:0]  cpu_wr_data, cpu_rd_data;
  logic        vblank_set, vblank_clr, spr0_set, ovf_set;
  logic [7:0]  ctrl, mask, scroll_x, scroll_y;
  logic        nmi;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wr_data, vram_rd_data, pal_rd_data;
  logic        vram_we, vram_re;
  logic        dma_active, dma_we;
  logic [7:0]  dma_oam_addr, dma_data;
  logic [7:0]  oam_addr, oam_wr_data, oam_rd_data;
  logic        oam_we;
  logic [2:0]  dbg_state;

  ppu_reg_file dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .reg_addr(reg_addr), .cpu_we(cpu_we),
    .cpu_re(cpu_re), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .vblank_set(vblank_set), .vblank_clr(vblank_clr), .spr0_set(spr0_set), .ovf_set(ovf_set),
    .ctrl(ctrl), .mask(mask), .scroll_x(scroll_x), .scroll_y(scroll_y), .nmi(nmi),
    .vram_addr(vram_addr), .vram_wr_data(vram_wr_data), .vram_we(vram_we), .vram_re(vram_re),
    .vram_rd_data(vram_rd_data), .pal_rd_data(pal_rd_data), .dma_active(dma_active),
    .dma_oam_addr(dma_oam_addr), .dma_data(dma_data), .dma_we(dma_we), .oam_addr(oam_addr),
    .oam_wr_data(oam_wr_data), .oam_we(oam_we), .oam_rd_data(oam_rd_data), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // VRAM model with one-cycle read latency
  logic [7:0] vram_mem [0:16383];
  always @(posedge clk) vram_rd_data <= vram_re ? vram_mem[vram_addr] : 8'h00;

  // scoreboards
  logic [21:0] vexp_q[$];
  logic [21:0] vact_q[$];
  logic [15:0] oexp_q[$];
  logic [15:0] oact_q[$];
  always @(negedge clk) begin
    if (vram_we) vact_q.push_back({vram_addr, vram_wr_data});
    if (oam_we)  oact_q.push_back({oam_addr, oam_wr_data});
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drain_vram(input string nm);
    chk({nm, " count"}, vact_q.size(), vexp_q.size());
    while (vact_q.size() > 0 && vexp_q.size() > 0)
      chk(nm, 32'(vact_q.pop_front()), 32'(vexp_q.pop_front()));
    vact_q.delete();
    vexp_q.delete();
  endtask

  task automatic drain_oam(input string nm);
    chk({nm, " count"}, oact_q.size(), oexp_q.size());
    while (oact_q.size() > 0 && oexp_q.size() > 0)
      chk(nm, 32'(oact_q.pop_front()), 32'(oexp_q.pop_front()));
    oact_q.delete();
    oexp_q.delete();
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs_n = 1'b0; reg_addr = a; cpu_we = 1'b1; cpu_wr_data = d;
    step();
    cs_n = 1'b1; cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    cs_n = 1'b0; reg_addr = a; cpu_re = 1'b1;
    #1 d = cpu_rd_data;
    step();
    cs_n = 1'b1; cpu_re = 1'b0;
  endtask

  task automatic vwr(input logic [7:0] d);
    wr(3'd7, d);
    idle(2);
  endtask

  task automatic vrd(output logic [7:0] d);
    rd(3'd7, d);
    idle(2);
  endtask

  task automatic pulse(input logic vs, input logic vc, input logic s0, input logic ov);
    vblank_set = vs; vblank_clr = vc; spr0_set = s0; ovf_set = ov;
    step();
    vblank_set = 1'b0; vblank_clr = 1'b0; spr0_set = 1'b0; ovf_set = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  a;
    logic [7:0]  d;
    logic [31:0] exp;  // {ctrl, mask, scroll_x, scroll_y}
  } wvec_t;
  wvec_t tbl [8];

  logic [7:0] r;

  initial begin
    tbl[0] = '{3'd0, 8'h01, 32'h01_00_00_00};
    tbl[1] = '{3'd1, 8'h1E, 32'h01_1E_00_00};
    tbl[2] = '{3'd5, 8'h7D, 32'h01_1E_7D_00};
    tbl[3] = '{3'd5, 8'h5E, 32'h01_1E_7D_5E};
    tbl[4] = '{3'd0, 8'h84, 32'h84_1E_7D_5E};
    tbl[5] = '{3'd5, 8'h03, 32'h84_1E_03_5E};
    tbl[6] = '{3'd5, 8'hF0, 32'h84_1E_03_F0};
    tbl[7] = '{3'd1, 8'h00, 32'h84_00_03_F0};

    for (int i = 0; i < 16384; i++) vram_mem[i] = 8'h00;
    vram_mem[14'h2000] = 8'h11;
    vram_mem[14'h2001] = 8'h22;
    vram_mem[14'h2002] = 8'h33;
    vram_mem[14'h3EFF] = 8'h44;
    vram_mem[14'h1234] = 8'h5A;

    reset = 1'b1; cs_n = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; reg_addr = '0; cpu_wr_data = '0;
    vblank_set = 1'b0; vblank_clr = 1'b0; spr0_set = 1'b0; ovf_set = 1'b0;
    pal_rd_data = 8'h0F; dma_active = 1'b0; dma_oam_addr = '0; dma_data = '0; dma_we = 1'b0;
    oam_rd_data = 8'h5C;
    idle(3);
    reset = 1'b0;
    step();

    // reset state
    chk("reset regs", {ctrl, mask, scroll_x, scroll_y}, 32'h0);
    chk("reset vram_addr", 32'(vram_addr), 32'h0);
    chk("reset oam_addr", 32'(oam_addr), 32'h0);
    chk("reset strobes/nmi", {28'h0, vram_we, vram_re, oam_we, nmi}, 32'h0);
    chk("reset state", 32'(dbg_state), 32'h0);

    // register write table
    for (int i = 0; i < 8; i++) begin
      wr(tbl[i].a, tbl[i].d);
      chk($sformatf("wr_table[%0d]", i), {ctrl, mask, scroll_x, scroll_y}, tbl[i].exp);
    end

    // reset in the middle of a PPUDATA read
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    wr(3'd0, 8'h80);
    chk("nmi before reset", 32'(nmi), 32'h1);
    wr(3'd6, 8'h12);
    wr(3'd6, 8'h34);
    vrd(r);
    rd(3'd7, r);
    chk("buffered read before reset", 32'(r), 32'h5A);
    chk("in V_RQ", {28'h0, vram_re, dbg_state}, {28'h0, 1'b1, 3'd3});
    reset = 1'b1;
    #1;
    chk("mid-reset vram_re", 32'(vram_re), 32'h0);
    chk("mid-reset vram_addr", 32'(vram_addr), 32'h0);
    chk("mid-reset ctrl/nmi", {23'h0, ctrl, nmi}, 32'h0);
    chk("mid-reset state", 32'(dbg_state), 32'h0);
    step();
    reset = 1'b0;
    step();
    rd(3'd7, r);
    chk("rd_buf after reset", 32'(r), 32'h0);
    idle(2);

    // PPUDATA writes, +1 then +32 increment, strobe ignored outside IDLE
    wr(3'd6, 8'h21); wr(3'd6, 8'h08);
    vwr(8'hAA); vwr(8'hAA);
    vexp_q.push_back({14'h2108, 8'hAA}); vexp_q.push_back({14'h2109, 8'hAA});
    chk("vram_addr inc1", 32'(vram_addr), 32'h210A);
    wr(3'd0, 8'h04);
    wr(3'd6, 8'h21); wr(3'd6, 8'h08);
    vwr(8'hAA); vwr(8'hAA);
    vexp_q.push_back({14'h2108, 8'hAA}); vexp_q.push_back({14'h2128, 8'hAA});
    chk("vram_addr inc32", 32'(vram_addr), 32'h2148);
    wr(3'd0, 8'h00);
    wr(3'd6, 8'h21); wr(3'd6, 8'h00);
    wr(3'd7, 8'hC1); wr(3'd7, 8'hC2); idle(2);
    vexp_q.push_back({14'h2100, 8'hC1});
    chk("busy strobe ignored", 32'(vram_addr), 32'h2101);
    drain_vram("vram writes");

    // PPUDATA buffered reads and palette bypass at the boundary
    wr(3'd6, 8'h20); wr(3'd6, 8'h00);
    vrd(r); chk("rd 2000 buffered", 32'(r), 32'h00);
    vrd(r); chk("rd 2001 buffered", 32'(r), 32'h11);
    vrd(r); chk("rd 2002 buffered", 32'(r), 32'h22);
    wr(3'd6, 8'h3E); wr(3'd6, 8'hFF);
    vrd(r); chk("rd 3EFF buffered", 32'(r), 32'h33);
    vrd(r); chk("rd 3F00 palette", 32'(r), 32'h0F);
    chk("vram_addr after reads", 32'(vram_addr), 32'h3F01);

    // vblank / NMI / STATUS
    pulse(1'b1, 1'b0, 1'b1, 1'b1);
    chk("nmi with ctrl7=0", 32'(nmi), 32'h0);
    wr(3'd0, 8'h93);
    chk("nmi rises", 32'(nmi), 32'h1);
    wr(3'd5, 8'h55);
    rd(3'd2, r); chk("status all flags", 32'(r), 32'hF5);
    chk("nmi falls", 32'(nmi), 32'h0);
    wr(3'd5, 8'h66);
    chk("w cleared by status", {16'h0, scroll_x, scroll_y}, 32'h6600);
    rd(3'd2, r); chk("status vblank cleared", 32'(r), 32'h66);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    rd(3'd2, r); chk("status after vblank_clr", 32'(r), 32'h06);

    // STATUS read racing vblank_set, and clr-over-set priority
    vblank_set = 1'b1;
    rd(3'd2, r);
    vblank_set = 1'b0;
    chk("race read bit7", 32'(r), 32'h06);
    rd(3'd2, r); chk("race set suppressed", 32'(r), 32'h06);
    chk("race nmi", 32'(nmi), 32'h0);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr beats set", 32'(nmi), 32'h0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("set after race", 32'(nmi), 32'h1);
    rd(3'd2, r); chk("status set again", 32'(r), 32'h86);

    // OAM DMA overrides the CPU port
    wr(3'd3, 8'h10);
    dma_active = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dma_oam_addr = 8'(i); dma_data = 8'(i) ^ 8'hA5; dma_we = 1'b1;
      oexp_q.push_back({8'(i), 8'(i) ^ 8'hA5});
      step();
    end
    dma_we = 1'b0;
    wr(3'd4, 8'hEE);
    idle(2);
    chk("dma addr passthrough", 32'(oam_addr), 32'hFF);
    dma_active = 1'b0;
    #1;
    chk("oam_addr kept across dma", 32'(oam_addr), 32'h10);
    drain_oam("dma writes");

    // CPU OAMDATA write/read and 8-bit wrap
    wr(3'd4, 8'h77); idle(2);
    oexp_q.push_back({8'h10, 8'h77});
    chk("oam_addr inc", 32'(oam_addr), 32'h11);
    rd(3'd4, r); chk("oamdata read", 32'(r), 32'h5C);
    idle(2);
    chk("oam read no inc", 32'(oam_addr), 32'h11);
    wr(3'd3, 8'hFF);
    wr(3'd4, 8'h12); idle(2);
    oexp_q.push_back({8'hFF, 8'h12});
    chk("oam_addr wrap", 32'(oam_addr), 32'h00);
    drain_oam("cpu oam writes");

    // VRAM address wrap
    wr(3'd6, 8'h3F); wr(3'd6, 8'hFF);
    vwr(8'hBB);
    vexp_q.push_back({14'h3FFF, 8'hBB});
    chk("vram_addr wrap", 32'(vram_addr), 32'h0000);
    drain_vram("vram wrap write");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
